// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS subset: opcode/funct codes,
// ALU operation encoding, decoded control bundle and the ALU datapath helper.
package mips_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_LUI
  } alu_op_t;

  typedef struct packed {
    logic reg_write;   // write a result to the register file
    logic mem_write;   // store rt to data memory
    logic mem_to_reg;  // writeback comes from data memory
    logic alu_src;     // ALU B operand is the extended immediate
    logic reg_dst;     // destination is rd (else rt)
    logic branch;      // beq
    logic branch_ne;   // bne
    logic jump;        // j / jal
    logic link;        // jal: write PC+4 to $31
    logic zero_ext;    // immediate is zero-extended
  } ctrl_t;

  // 32-bit wrap-around ALU; shifts act on B (rt) by shamt, LUI moves B[15:0] up.
  function automatic logic [31:0] alu_compute(input alu_op_t op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [4:0] shamt);
    logic [31:0] r;
    r = '0;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'b0, a < b};
      ALU_SLL:  r = b << shamt;
      ALU_SRL:  r = b >> shamt;
      ALU_LUI:  r = {b[15:0], 16'h0000};
      default:  r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_single_cycle_processor_if.sv
// Fetch-unit link between the core datapath (master) and the IFU (slave).
// There is no handshake: every field is valid in every cycle, the IFU presents
// the current PC and instruction combinationally and consumes the branch/jump
// decision at the same rising edge that retires the instruction.
interface mips_single_cycle_processor_if;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        branch_taken;
  logic [31:0] branch_off;
  logic        jump;
  logic [25:0] jump_target;

  modport master (input pc, pc_plus4, instr,
                  output branch_taken, branch_off, jump, jump_target);
  modport slave  (output pc, pc_plus4, instr,
                  input branch_taken, branch_off, jump, jump_target);
endinterface

// File: rtl/mips_byte_mem.sv
// Big-endian byte array with a combinational word read and a posedge word write.
// Word accesses ignore addr[1:0]; the address wraps modulo the memory size.
module mips_byte_mem #(
  parameter int unsigned BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  localparam int unsigned AW = $clog2(BYTES);

  reg   [7:0]    bytes [0:BYTES-1];
  logic [AW-3:0] word_idx;
  logic          unused_addr_bits;

  assign word_idx         = addr_i[AW-1:2];
  assign unused_addr_bits = &{1'b0, addr_i[31:AW], addr_i[1:0]};

  assign rdata_o = {bytes[{word_idx, 2'd0}], bytes[{word_idx, 2'd1}],
                    bytes[{word_idx, 2'd2}], bytes[{word_idx, 2'd3}]};

  // Word store; plain always so the array can also be preloaded hierarchically.
  always @(posedge clk_i) begin
    if (we_i) begin
      bytes[{word_idx, 2'd0}] <= wdata_i[31:24];
      bytes[{word_idx, 2'd1}] <= wdata_i[23:16];
      bytes[{word_idx, 2'd2}] <= wdata_i[15:8];
      bytes[{word_idx, 2'd3}] <= wdata_i[7:0];
    end
  end
endmodule

// File: rtl/mips_imemory.sv
// Read-only instruction memory wrapper around the byte storage.
module mips_imemory #(
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic [31:0] addr_i,
  output logic [31:0] instr_o
);
  mips_byte_mem #(.BYTES(IMEM_BYTES)) storage (
    .clk_i   (clk_i),
    .we_i    (1'b0),
    .addr_i  (addr_i),
    .wdata_i (32'h0),
    .rdata_o (instr_o)
  );
endmodule

// File: rtl/mips_single_cycle_processor_ifu.sv
// Instruction fetch unit: PC register, next-PC selection and instruction memory.
module mips_single_cycle_processor_ifu
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk_i,
  input logic rst_ni,
  mips_single_cycle_processor_if.slave fetch_if
);
  logic [31:0] pc_q = 32'h0;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;

  assign pc_plus4          = pc_q + 32'd4;
  assign fetch_if.pc       = pc_q;
  assign fetch_if.pc_plus4 = pc_plus4;

  mips_imemory #(.IMEM_BYTES(IMEM_BYTES)) imemory (
    .clk_i   (clk_i),
    .addr_i  (pc_q),
    .instr_o (fetch_if.instr)
  );

  // Next PC: jump beats branch, default is the sequential instruction.
  always_comb begin
    pc_d = pc_plus4;
    if (fetch_if.jump) begin
      pc_d = {pc_plus4[31:28], fetch_if.jump_target, 2'b00};
    end else if (fetch_if.branch_taken) begin
      pc_d = pc_plus4 + fetch_if.branch_off;
    end
  end

  // PC register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) pc_q <= RESET_PC;
    else         pc_q <= pc_d;
  end
endmodule

// File: rtl/mips_single_cycle_processor.sv
// Single-cycle MIPS subset core: decode, register file, ALU, data memory and
// writeback around the IFU. Every instruction retires at one rising edge.
module mips_single_cycle_processor
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 1024,
  parameter int unsigned DMEM_BYTES = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_o
);
  mips_single_cycle_processor_if fetch_if ();

  mips_single_cycle_processor_ifu #(
    .IMEM_BYTES (IMEM_BYTES),
    .RESET_PC   (RESET_PC)
  ) IFU (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .fetch_if (fetch_if)
  );

  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  ctrl_t       ctrl;
  alu_op_t     alu_op;

  assign instr  = fetch_if.instr;
  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  // Decode; anything unrecognised leaves every control bit clear (a NOP).
  always_comb begin
    ctrl   = '0;
    alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_XOR:          alu_op = ALU_XOR;
          FN_NOR:          alu_op = ALU_NOR;
          FN_SLT:          alu_op = ALU_SLT;
          FN_SLTU:         alu_op = ALU_SLTU;
          FN_SLL:          alu_op = ALU_SLL;
          FN_SRL:          alu_op = ALU_SRL;
          default:         ctrl.reg_write = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1;
      end
      OP_SLTI: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; alu_op = ALU_SLT;
      end
      OP_ANDI: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.zero_ext = 1'b1; alu_op = ALU_AND;
      end
      OP_ORI: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.zero_ext = 1'b1; alu_op = ALU_OR;
      end
      OP_XORI: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.zero_ext = 1'b1; alu_op = ALU_XOR;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; alu_op = ALU_LUI;
      end
      OP_LW: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.mem_to_reg = 1'b1;
      end
      OP_SW:  begin ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; end
      OP_BEQ: ctrl.branch    = 1'b1;
      OP_BNE: ctrl.branch_ne = 1'b1;
      OP_J:   ctrl.jump      = 1'b1;
      OP_JAL: begin
        ctrl.jump = 1'b1; ctrl.link = 1'b1; ctrl.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Register file: $0 is never written and always reads as zero.
  logic [31:0] regs_q [32] = '{default: 32'h0};
  logic [31:0] rs_val, rt_val;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data_d;

  assign rs_val = (rs == 5'd0) ? 32'h0 : regs_q[rs];
  assign rt_val = (rt == 5'd0) ? 32'h0 : regs_q[rt];

  logic [31:0] imm_ext, alu_b, alu_result, dmem_rdata;
  logic        rs_eq_rt;

  assign imm_ext    = ctrl.zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  assign alu_b      = ctrl.alu_src ? imm_ext : rt_val;
  assign alu_result = alu_compute(alu_op, rs_val, alu_b, shamt);
  assign rs_eq_rt   = (rs_val == rt_val);

  // A store in a reset cycle is dropped along with the rest of the instruction.
  mips_byte_mem #(.BYTES(DMEM_BYTES)) dmemory (
    .clk_i   (clk),
    .we_i    (ctrl.mem_write & rst_n),
    .addr_i  (alu_result),
    .wdata_i (rt_val),
    .rdata_o (dmem_rdata)
  );

  assign wb_addr   = ctrl.link ? 5'd31 : (ctrl.reg_dst ? rd : rt);
  assign wb_data_d = ctrl.link       ? fetch_if.pc_plus4 :
                     ctrl.mem_to_reg ? dmem_rdata : alu_result;

  // Register writeback; reset clears the whole file and masks this cycle's write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
    end else if (ctrl.reg_write && (wb_addr != 5'd0)) begin
      regs_q[wb_addr] <= wb_data_d;
    end
  end

  assign fetch_if.branch_taken = (ctrl.branch & rs_eq_rt) | (ctrl.branch_ne & ~rs_eq_rt);
  assign fetch_if.branch_off   = {imm_ext[29:0], 2'b00};
  assign fetch_if.jump         = ctrl.jump;
  assign fetch_if.jump_target  = instr[25:0];

  assign pc_o = fetch_if.pc;
endmodule

// File: tb/tb_mips_single_cycle_processor.sv
// Bench for the single-cycle MIPS core: directed programs plus random programs,
// checked against an instruction-level interpreter kept in the bench.
module tb_mips_single_cycle_processor;
  localparam int unsigned IMEM   = 1024;
  localparam int unsigned DMEM   = 1024;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_o;

  always #5 clk = ~clk;

  mips_single_cycle_processor #(
    .IMEM_BYTES (IMEM),
    .DMEM_BYTES (DMEM),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pc_o  (pc_o)
  );

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  // ---------------- reference model state ----------------
  logic [7:0]  m_imem   [IMEM];
  logic [7:0]  m_dmem   [DMEM];
  logic [7:0]  pre_dmem [DMEM];
  logic [31:0] m_regs   [32];
  logic [31:0] m_pc;
  logic [31:0] prog[$];

  logic [5:0] rfn  [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                           6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h01};
  logic [5:0] iops [7]  = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

  // ---------------- encoders ----------------
  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [31:0] addr);
    return {op, addr[27:2]};
  endfunction

  // ---------------- reference model: one instruction ----------------
  function automatic void model_step();
    logic [31:0] ins, a, b, se, ze, v, npc;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh, dst;
    logic        wr;
    int unsigned addr;
    addr = m_pc % IMEM;
    addr = addr - addr % 4;
    ins  = {m_imem[addr], m_imem[addr+1], m_imem[addr+2], m_imem[addr+3]};
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    sh = ins[10:6];  fn = ins[5:0];
    a  = m_regs[rs]; b = m_regs[rt];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0000, ins[15:0]};
    npc = m_pc + 32'd4; wr = 1'b0; v = 32'h0; dst = rt;
    case (op)
      6'h00: begin
        dst = rd; wr = 1'b1;
        case (fn)
          6'h20, 6'h21: v = a + b;
          6'h22, 6'h23: v = a - b;
          6'h24: v = a & b;
          6'h25: v = a | b;
          6'h26: v = a ^ b;
          6'h27: v = ~(a | b);
          6'h2A: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2B: v = (a < b) ? 32'd1 : 32'd0;
          6'h00: v = b << sh;
          6'h02: v = b >> sh;
          default: wr = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin v = a + se; wr = 1'b1; end
      6'h0A: begin v = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; wr = 1'b1; end
      6'h0C: begin v = a & ze; wr = 1'b1; end
      6'h0D: begin v = a | ze; wr = 1'b1; end
      6'h0E: begin v = a ^ ze; wr = 1'b1; end
      6'h0F: begin v = {ins[15:0], 16'h0000}; wr = 1'b1; end
      6'h23: begin
        addr = (a + se) % DMEM; addr = addr - addr % 4;
        v = {m_dmem[addr], m_dmem[addr+1], m_dmem[addr+2], m_dmem[addr+3]};
        wr = 1'b1;
      end
      6'h2B: begin
        addr = (a + se) % DMEM; addr = addr - addr % 4;
        m_dmem[addr]   = b[31:24];
        m_dmem[addr+1] = b[23:16];
        m_dmem[addr+2] = b[15:8];
        m_dmem[addr+3] = b[7:0];
      end
      6'h04: if (a == b) npc = npc + (se << 2);
      6'h05: if (a != b) npc = npc + (se << 2);
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      6'h03: begin
        v = m_pc + 32'd4; dst = 5'd31; wr = 1'b1;
        npc = {npc[31:28], ins[25:0], 2'b00};
      end
      default: ;
    endcase
    if (wr && dst != 5'd0) m_regs[dst] = v;
    m_pc = npc;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_memories();
    logic [31:0] w;
    logic [7:0]  bv;
    for (int i = 0; i < IMEM; i++) begin
      w  = (i / 4 < prog.size()) ? prog[i / 4] : 32'h0;
      bv = w[8 * (3 - i % 4) +: 8];
      dut.IFU.imemory.storage.bytes[i] = bv;
      m_imem[i] = bv;
    end
    for (int i = 0; i < DMEM; i++) begin
      bv = 8'($urandom_range(0, 253));
      dut.dmemory.bytes[i] = bv;
      m_dmem[i]   = bv;
      pre_dmem[i] = bv;
    end
  endtask

  // One reset cycle; optionally reload both memories first.
  task automatic reset_cycle(input bit reload);
    @(negedge clk);
    rst_n = 1'b0;
    if (reload) load_memories();
    m_pc = RST_PC;
    for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
    exp_q.push_back(RST_PC);
  endtask

  task automatic run_steps(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst_n = 1'b1;
      model_step();
      exp_q.push_back(m_pc);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // ---------------- checkers ----------------
  task automatic check_word(input string name, input int unsigned a, input logic [31:0] exp);
    logic [31:0] act;
    act = {dut.dmemory.bytes[a], dut.dmemory.bytes[a+1],
           dut.dmemory.bytes[a+2], dut.dmemory.bytes[a+3]};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: dmem word @%0d = %h, expected %h", name, a, act, exp);
    end
  endtask

  task automatic check_mem_model(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < DMEM; i++)
      if (bad < 0 && dut.dmemory.bytes[i] !== m_dmem[i]) bad = i;
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: dmem byte %0d = %h, expected %h", name, bad,
               dut.dmemory.bytes[bad], m_dmem[bad]);
    end
  endtask

  task automatic check_fill(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < 64; i++)
      if (bad < 0 && dut.dmemory.bytes[i] !== 8'hFE) bad = i;
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: dmem byte %0d = %h, expected fe", name, bad, dut.dmemory.bytes[bad]);
    end
  endtask

  // ---------------- monitor: PC trace ----------------
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (pc_o !== e) begin
          n_fail++;
          $display("FAIL pc_trace: pc_o = %h, expected %h", pc_o, e);
        end
      end
    end
  end

  // ---------------- programs ----------------
  task automatic build_fill();
    prog.delete();
    prog.push_back(i_ins(6'h0F, 0, 8, 16'hFEFE));       // lui  $8,0xFEFE
    prog.push_back(i_ins(6'h0D, 8, 8, 16'hFEFE));       // ori  $8,$8,0xFEFE
    prog.push_back(i_ins(6'h08, 0, 9, 16'h0000));       // addi $9,$0,0
    prog.push_back(i_ins(6'h08, 0, 10, 16'h0040));      // addi $10,$0,64
    prog.push_back(i_ins(6'h2B, 9, 8, 16'h0000));       // sw   $8,0($9)
    prog.push_back(i_ins(6'h08, 9, 9, 16'h0004));       // addi $9,$9,4
    prog.push_back(i_ins(6'h05, 9, 10, 16'hFFFD));      // bne  $9,$10,loop
    prog.push_back(j_ins(6'h02, 32'd28));               // j    self
  endtask

  task automatic build_alu();
    prog.delete();
    prog.push_back(i_ins(6'h08, 0, 1, 16'h0005));
    prog.push_back(i_ins(6'h08, 0, 2, 16'hFFFD));
    prog.push_back(r_ins(6'h20, 1, 2, 3, 0));           // add
    prog.push_back(r_ins(6'h22, 1, 2, 4, 0));           // sub
    prog.push_back(r_ins(6'h24, 1, 2, 5, 0));           // and
    prog.push_back(r_ins(6'h25, 1, 2, 6, 0));           // or
    prog.push_back(r_ins(6'h2A, 2, 1, 7, 0));           // slt  -3 < 5
    prog.push_back(r_ins(6'h2B, 2, 1, 8, 0));           // sltu 0xFFFFFFFD < 5
    for (int r = 3; r <= 8; r++) prog.push_back(i_ins(6'h2B, 0, 5'(r), 16'(4 * (r - 3))));
    prog.push_back(j_ins(6'h02, 32'd56));
  endtask

  task automatic build_endian();
    prog.delete();
    prog.push_back(i_ins(6'h0F, 0, 1, 16'h1234));
    prog.push_back(i_ins(6'h0D, 1, 1, 16'h5678));
    prog.push_back(i_ins(6'h2B, 0, 1, 16'd8));
    prog.push_back(i_ins(6'h23, 0, 9, 16'd8));
    prog.push_back(i_ins(6'h2B, 0, 9, 16'd12));
    prog.push_back(j_ins(6'h02, 32'd20));
  endtask

  task automatic build_ctrl();
    prog.delete();
    prog.push_back(i_ins(6'h08, 0, 1, 16'h0001));       // 0  addi $1,$0,1
    prog.push_back(i_ins(6'h04, 0, 0, 16'h0001));       // 4  beq  taken -> 12
    prog.push_back(i_ins(6'h08, 0, 2, 16'h0055));       // 8  skipped
    prog.push_back(i_ins(6'h05, 1, 1, 16'h0001));       // 12 bne not taken
    prog.push_back(i_ins(6'h08, 0, 3, 16'h0033));       // 16
    prog.push_back(j_ins(6'h03, 32'd36));               // 20 jal 36
    prog.push_back(i_ins(6'h08, 0, 4, 16'h0044));       // 24
    prog.push_back(j_ins(6'h02, 32'd48));               // 28 j 48
    prog.push_back(i_ins(6'h08, 0, 5, 16'h0066));       // 32 never reached
    prog.push_back(i_ins(6'h08, 0, 6, 16'h0077));       // 36
    prog.push_back(j_ins(6'h02, 32'd24));               // 40 j 24
    prog.push_back(32'h0);                              // 44 nop
    prog.push_back(i_ins(6'h08, 0, 0, 16'h0007));       // 48 addi $0,$0,7
    prog.push_back(i_ins(6'h2B, 0, 0, 16'd0));          // 52 sw $0,0
    prog.push_back(i_ins(6'h2B, 0, 2, 16'd4));          // 56 sw $2,4
    prog.push_back(i_ins(6'h2B, 0, 3, 16'd8));          // 60 sw $3,8
    prog.push_back(i_ins(6'h2B, 0, 31, 16'd12));        // 64 sw $31,12
    prog.push_back(i_ins(6'h2B, 0, 4, 16'd16));         // 68 sw $4,16
    prog.push_back(i_ins(6'h2B, 0, 6, 16'd20));         // 72 sw $6,20
    prog.push_back(i_ins(6'h2B, 0, 5, 16'd24));         // 76 sw $5,24
    prog.push_back(j_ins(6'h02, 32'd80));               // 80 j self
  endtask

  task automatic build_random();
    int          kind;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    prog.delete();
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      rs   = 5'($urandom_range(0, 7));
      rt   = 5'($urandom_range(0, 7));
      rd   = 5'($urandom_range(0, 7));
      imm  = 16'($urandom);
      case (kind)
        0, 1, 2, 9: prog.push_back(r_ins(rfn[$urandom_range(0, 12)], rs, rt, rd, 5'($urandom)));
        3, 4:       prog.push_back(i_ins(iops[$urandom_range(0, 6)], rs, rt, imm));
        5:          prog.push_back(i_ins(6'h23, rs, rt, imm));
        6:          prog.push_back(i_ins(6'h2B, rs, rt, imm));
        7:          prog.push_back(i_ins(($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05, rs, rt,
                                         16'($urandom_range(0, 3))));
        default:    prog.push_back({6'h3F, 26'($urandom)});
      endcase
    end
    for (int r = 1; r < 8; r++) prog.push_back(i_ins(6'h2B, 0, 5'(r), 16'(512 + 4 * r)));
    prog.push_back(j_ins(6'h02, 32'(prog.size() * 4)));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Fill loop, reset state and memory retention across reset
    build_fill();
    reset_cycle(1'b1);
    settle();
    check_mem_model("reset_keeps_dmem");
    run_steps(19);
    settle();
    check_word("fill_first_word", 0, 32'hFEFEFEFE);
    run_steps(41);
    settle();
    check_fill("fill_words_0_63");
    check_word("fill_word64_untouched", 64,
               {pre_dmem[64], pre_dmem[65], pre_dmem[66], pre_dmem[67]});
    check_mem_model("fill_model");

    // Reset in the cycle of the third store (to address 8)
    build_fill();
    reset_cycle(1'b1);
    run_steps(10);
    reset_cycle(1'b0);
    settle();
    check_word("midreset_prior_store0", 0, 32'hFEFEFEFE);
    check_word("midreset_prior_store4", 4, 32'hFEFEFEFE);
    check_word("midreset_store_suppressed", 8,
               {pre_dmem[8], pre_dmem[9], pre_dmem[10], pre_dmem[11]});
    run_steps(60);
    settle();
    check_mem_model("midreset_rerun_model");

    // ALU operations
    build_alu();
    reset_cycle(1'b1);
    run_steps(16);
    settle();
    check_word("alu_add", 0, 32'd2);
    check_word("alu_sub", 4, 32'd8);
    check_word("alu_and", 8, 32'd5);
    check_word("alu_or", 12, 32'hFFFFFFFD);
    check_word("alu_slt", 16, 32'd1);
    check_word("alu_sltu", 20, 32'd0);
    check_mem_model("alu_model");

    // Big-endian store/load
    build_endian();
    reset_cycle(1'b1);
    run_steps(8);
    settle();
    check_word("endian_sw", 8, 32'h12345678);
    check_word("endian_lw_sw", 12, 32'h12345678);
    check_mem_model("endian_model");

    // Branches, jumps, jal link and $0 protection
    build_ctrl();
    reset_cycle(1'b1);
    run_steps(24);
    settle();
    check_word("zero_reg_protect", 0, 32'h0);
    check_word("beq_skip", 4, 32'h0);
    check_word("bne_fallthrough", 8, 32'h33);
    check_word("jal_link", 12, 32'd24);
    check_word("jal_return_path", 16, 32'h44);
    check_word("jal_target", 20, 32'h77);
    check_word("j_skip", 24, 32'h0);
    check_mem_model("ctrl_model");

    // Random programs against the interpreter
    for (int p = 0; p < 4; p++) begin
      build_random();
      reset_cycle(1'b1);
      run_steps(60);
      settle();
      check_mem_model("random_program");
    end

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drained: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
